spi_data_shifter: RTL and testbench
===================================

Name: spi_data_shifter

Overview:
- Serial data path that sits directly downstream of the SPI baud generator.
- Consumes the generator's send and receive strobes (mosi_send_sclk/_sclk0, miso_recieve_sclk/_sclk0).
- Serialises a parallel TX byte onto mosi_o and deserialises miso_i into a parallel RX byte.
- Reports transfer completion to the SPI control/APB slave interface.

Parameters:
- DATA_W, 8, transfer width in bits (legal range 2..16).

Ports:
- PCLK  input  1  system clock
- PRESET_n  input  1  reset
- ss_i  input  1  slave select, active low; high aborts any transfer
- cpol_i  input  1  clock polarity
- cpha_i  input  1  clock phase
- lsbfe_i  input  1  1 = LSB first, 0 = MSB first; latched at load
- send_data_i  input  1  single-cycle load request from the control block
- data_mosi_i  input  DATA_W  parallel TX data
- mosi_send_sclk_i  input  1  send strobe, CPOL==CPHA modes
- mosi_send_sclk0_i  input  1  send strobe, CPOL!=CPHA modes
- miso_recieve_sclk_i  input  1  receive strobe, CPOL==CPHA modes
- miso_recieve_sclk0_i  input  1  receive strobe, CPOL!=CPHA modes
- miso_i  input  1  serial input
- mosi_o  output  1  serial output
- data_miso_o  output  DATA_W  last completed RX word
- busy_o  output  1  transfer in progress
- done_o  output  1  one-cycle completion pulse

Behaviour:
- Reset: PRESET_n, asynchronous, active-low; clock PCLK. All outputs and internal state reset to 0; FSM resets to IDLE.
- Strobe select (combinational):
  - cpol_i^cpha_i = 1: S = mosi_send_sclk0_i, R = miso_recieve_sclk0_i.
  - Otherwise: S = mosi_send_sclk_i, R = miso_recieve_sclk_i.
  - Unselected strobes are ignored.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - send_data_i=1 and ss_i=0: tx_sr <= data_mosi_i, lsb_q <= lsbfe_i, tx_cnt <= 0, rx_cnt <= 0, busy_o <= 1, go to SHIFT.
  - send_data_i with ss_i=1: ignored.
- SHIFT, per-cycle actions (S and R in the same cycle are both processed independently):
  - S and tx_cnt<DATA_W: mosi_o <= tx_sr[DATA_W-1] (MSB-first) or tx_sr[0] (LSB-first); tx_sr shifts toward the taken end, zero fill; tx_cnt++. S with tx_cnt==DATA_W is ignored.
  - R: MSB-first, rx_sr <= {rx_sr[DATA_W-2:0], miso_i}; LSB-first, rx_sr <= {miso_i, rx_sr[DATA_W-1:1]}; rx_cnt++.
- SHIFT → DONE: on the R that makes rx_cnt==DATA_W, data_miso_o <= assembled word (including that bit), same edge.
- DONE: done_o=1 for exactly one cycle; busy_o <= 0; go to IDLE. data_miso_o holds until the next completion.
- send_data_i in SHIFT or DONE: ignored; the transfer is not disturbed.
- ss_i=1 in SHIFT: abort to IDLE next edge. busy_o <= 0, counters cleared, no done_o, data_miso_o unchanged, mosi_o holds its last value.
- mosi_o otherwise holds its value between strobes and across IDLE.
- Counter width: $clog2(DATA_W+1).
- Latency: load to busy_o = 1 cycle; final R to done_o = 1 cycle.

Optional Feature:
- Macro: SPI_SHIFT_OVERRUN_EN.
- Defined: adds output overrun_o (1 bit, reset 0). It is set sticky when send_data_i=1 while busy_o=1, and cleared on the next accepted load in IDLE. If load and clear coincide, the load wins, so overrun_o ends at 0.
- Undefined: no port, no logic; the ignore behaviour is unchanged.

Decomposition:
- Shared package spi_pkg:
  - constant SPI_DATA_W = 8
  - shifter state typedef {IDLE, SHIFT, DONE}
  - bit-order enum {MSB_FIRST, LSB_FIRST}
- Sub-module spi_strobe_select: combinational cpol/cpha mux producing S and R. It is reused by the slave-select control block.
- The shift FSM stays in spi_data_shifter.

Test Plan:
- Mode 0, MSB first: load 0xA5, miso pattern 0x3C on 8 R strobes → mosi_o sequence 1,0,1,0,0,1,0,1; data_miso_o=0x3C; one done_o pulse; busy_o low after.
- Mode 1 (cpha=1, cpol=0), LSB first: load 0x81, miso bits 1,1,0,0,0,0,0,0 → mosi_o 1,0,0,0,0,0,0,1; data_miso_o=0x03. Plain (non-0) strobes pulsed during the transfer produce no effect.
- Abort: load 0xFF, raise ss_i after 3 R strobes → busy_o=0 next cycle; no done_o; data_miso_o keeps the previous 0x03; a following 0x55 transfer completes normally.
- Same-cycle S and R on every bit, load 0x0F, miso=1 throughout → mosi_o 0,0,0,0,1,1,1,1; data_miso_o=0xFF.
- Extra send_data_i mid-transfer with data_mosi_i=0x00 → the original 0x5A is still shifted out. With SPI_SHIFT_OVERRUN_EN, overrun_o=1 until the next load.
- Reset asserted mid-SHIFT → mosi_o, data_miso_o, busy_o and done_o all 0 immediately; FSM in IDLE.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI serial data path.
//   SPI_DATA_W    : default transfer width in bits
//   shift_state_e : data shifter FSM states (IDLE, SHIFT, DONE)
//   bit_order_e   : serial bit order (MSB_FIRST, LSB_FIRST)
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_e;

  typedef enum logic {
    MSB_FIRST = 1'b0,
    LSB_FIRST = 1'b1
  } bit_order_e;

endpackage

// File: rtl/spi_strobe_select.sv
// -----------------------------------------------------------------------------
// spi_strobe_select
// Picks the send/receive strobe pair that matches the active SPI mode.
// Modes with cpol != cpha use the *_sclk0 strobes, the others the *_sclk ones.
// Purely combinational; shared with the slave-select control block.
// Ports:
//   cpol, cpha        : SPI clock polarity / phase
//   send_sclk/_sclk0  : send strobes from the baud generator
//   recv_sclk/_sclk0  : receive strobes from the baud generator
//   send, recv        : selected send / receive strobe
// -----------------------------------------------------------------------------
module spi_strobe_select (
  input  logic cpol,
  input  logic cpha,
  input  logic send_sclk,
  input  logic send_sclk0,
  input  logic recv_sclk,
  input  logic recv_sclk0,
  output logic send,
  output logic recv
);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    send = send_sclk;
    recv = recv_sclk;
    if (cpol ^ cpha) begin
      send = send_sclk0;
      recv = recv_sclk0;
    end
  end

endmodule

// File: rtl/spi_data_shifter.sv
// -----------------------------------------------------------------------------
// spi_data_shifter
// Serial data path behind the SPI baud generator. Loads a parallel TX word,
// shifts it out on mosi_o on each selected send strobe, assembles miso_i into
// an RX word on each selected receive strobe, and pulses done_o once the
// last RX bit has arrived. Raising ss_i during a transfer aborts it.
//
// Optional build macro SPI_SHIFT_OVERRUN_EN adds overrun_o, a sticky flag
// raised by a load request while busy and cleared by the next accepted load.
//
// Ports:
//   PCLK, PRESET_n          : clock, asynchronous active-low reset
//   ss_i                    : slave select (active low, high aborts)
//   cpol_i, cpha_i          : SPI mode
//   lsbfe_i                 : 1 = LSB first (latched at load)
//   send_data_i             : single-cycle load request
//   data_mosi_i             : parallel TX word
//   mosi_send_sclk_i/_sclk0 : send strobes
//   miso_recieve_sclk_i/_sclk0 : receive strobes
//   miso_i / mosi_o         : serial in / out
//   data_miso_o             : last completed RX word
//   busy_o                  : transfer in progress
//   done_o                  : one-cycle completion pulse
//   overrun_o               : (SPI_SHIFT_OVERRUN_EN only) load-while-busy flag
// -----------------------------------------------------------------------------
module spi_data_shifter
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic              PCLK,
  input  logic              PRESET_n,
  input  logic              ss_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsbfe_i,
  input  logic              send_data_i,
  input  logic [DATA_W-1:0] data_mosi_i,
  input  logic              mosi_send_sclk_i,
  input  logic              mosi_send_sclk0_i,
  input  logic              miso_recieve_sclk_i,
  input  logic              miso_recieve_sclk0_i,
  input  logic              miso_i,
  output logic              mosi_o,
  output logic [DATA_W-1:0] data_miso_o,
  output logic              busy_o,
  output logic              done_o
`ifdef SPI_SHIFT_OVERRUN_EN
  ,
  output logic              overrun_o
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  shift_state_e      state;
  shift_state_e      state_next;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rx_next;
  logic [CNT_W-1:0]  tx_cnt;
  logic [CNT_W-1:0]  rx_cnt;
  bit_order_e        order_q;
  logic              send_stb;
  logic              recv_stb;
  logic              load;
  logic              shifting;
  logic              last_rx;

  spi_strobe_select u_strobe_select (
    .cpol       (cpol_i),
    .cpha       (cpha_i),
    .send_sclk  (mosi_send_sclk_i),
    .send_sclk0 (mosi_send_sclk0_i),
    .recv_sclk  (miso_recieve_sclk_i),
    .recv_sclk0 (miso_recieve_sclk0_i),
    .send       (send_stb),
    .recv       (recv_stb)
  );

  assign load     = (state == IDLE) && send_data_i && !ss_i;
  // Abort (ss_i high) takes priority over any strobe in the same cycle.
  assign shifting = (state == SHIFT) && !ss_i;
  assign last_rx  = shifting && recv_stb && (rx_cnt == CNT_LAST);

  // RX word including the bit arriving this cycle; also the value captured
  // into data_miso_o on the final receive strobe.
  always_comb begin
    rx_next = {rx_sr[DATA_W-2:0], miso_i};
    if (order_q == LSB_FIRST) begin
      rx_next = {miso_i, rx_sr[DATA_W-1:1]};
    end
  end

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = SHIFT;
      SHIFT: begin
        if (ss_i)         state_next = IDLE;
        else if (last_rx) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    done_o = (state == DONE);
  end

  // Datapath: shift registers, counters, serial and parallel outputs.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      tx_sr       <= '0;
      rx_sr       <= '0;
      tx_cnt      <= '0;
      rx_cnt      <= '0;
      order_q     <= MSB_FIRST;
      mosi_o      <= 1'b0;
      data_miso_o <= '0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            tx_sr   <= data_mosi_i;
            order_q <= bit_order_e'(lsbfe_i);
            tx_cnt  <= '0;
            rx_cnt  <= '0;
            busy_o  <= 1'b1;
          end
        end
        SHIFT: begin
          if (ss_i) begin
            tx_cnt <= '0;
            rx_cnt <= '0;
            busy_o <= 1'b0;
          end else begin
            // Send strobes beyond the word length are ignored.
            if (send_stb && (tx_cnt < CNT_FULL)) begin
              if (order_q == LSB_FIRST) begin
                mosi_o <= tx_sr[0];
                tx_sr  <= tx_sr >> 1;
              end else begin
                mosi_o <= tx_sr[DATA_W-1];
                tx_sr  <= tx_sr << 1;
              end
              tx_cnt <= tx_cnt + CNT_W'(1);
            end
            if (recv_stb) begin
              rx_sr  <= rx_next;
              rx_cnt <= rx_cnt + CNT_W'(1);
              if (last_rx) begin
                data_miso_o <= rx_next;
              end
            end
          end
        end
        DONE: begin
          busy_o <= 1'b0;
        end
        default: begin
          busy_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_SHIFT_OVERRUN_EN
  // Sticky load-while-busy flag; an accepted load clears it and wins a tie.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      overrun_o <= 1'b0;
    end else if (load) begin
      overrun_o <= 1'b0;
    end else if (send_data_i && busy_o) begin
      overrun_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_data_shifter.sv
// -----------------------------------------------------------------------------
// tb_spi_data_shifter
// Self-checking bench for spi_data_shifter (DATA_W = 8): a table of directed
// transfers, hand-written abort / overlapping-load / reset sequences, and
// randomized transfers checked against a bit-order reference model.
// -----------------------------------------------------------------------------
module tb_spi_data_shifter;

  localparam int W = 8;

  logic         PCLK;
  logic         PRESET_n;
  logic         ss_i;
  logic         cpol_i;
  logic         cpha_i;
  logic         lsbfe_i;
  logic         send_data_i;
  logic [W-1:0] data_mosi_i;
  logic         mosi_send_sclk_i;
  logic         mosi_send_sclk0_i;
  logic         miso_recieve_sclk_i;
  logic         miso_recieve_sclk0_i;
  logic         miso_i;
  logic         mosi_o;
  logic [W-1:0] data_miso_o;
  logic         busy_o;
  logic         done_o;
`ifdef SPI_SHIFT_OVERRUN_EN
  logic         overrun_o;
`endif

  spi_data_shifter #(.DATA_W(W)) dut (
    .PCLK                 (PCLK),
    .PRESET_n             (PRESET_n),
    .ss_i                 (ss_i),
    .cpol_i               (cpol_i),
    .cpha_i               (cpha_i),
    .lsbfe_i              (lsbfe_i),
    .send_data_i          (send_data_i),
    .data_mosi_i          (data_mosi_i),
    .mosi_send_sclk_i     (mosi_send_sclk_i),
    .mosi_send_sclk0_i    (mosi_send_sclk0_i),
    .miso_recieve_sclk_i  (miso_recieve_sclk_i),
    .miso_recieve_sclk0_i (miso_recieve_sclk0_i),
    .miso_i               (miso_i),
    .mosi_o               (mosi_o),
    .data_miso_o          (data_miso_o),
    .busy_o               (busy_o),
    .done_o               (done_o)
`ifdef SPI_SHIFT_OVERRUN_EN
    ,
    .overrun_o            (overrun_o)
`endif
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: bit i of the result is the i-th serial bit on mosi_o.
  function automatic logic [W-1:0] model_mosi(input logic [W-1:0] tx, input logic lsb);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = lsb ? tx[i] : tx[W-1-i];
    return r;
  endfunction

  // Reference model: serial bit i (i-th received) lands at its word position.
  function automatic logic [W-1:0] model_rx(input logic [W-1:0] serial, input logic lsb);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      if (lsb) r[i] = serial[i];
      else     r[W-1-i] = serial[i];
    end
    return r;
  endfunction

  // Drive the mode-selected strobe pair with s/r; the other pair gets 'other'.
  task automatic strobes(input logic s, input logic r, input logic other);
    if (cpol_i ^ cpha_i) begin
      mosi_send_sclk0_i    = s;
      miso_recieve_sclk0_i = r;
      mosi_send_sclk_i     = other;
      miso_recieve_sclk_i  = other;
    end else begin
      mosi_send_sclk_i     = s;
      miso_recieve_sclk_i  = r;
      mosi_send_sclk0_i    = other;
      miso_recieve_sclk0_i = other;
    end
  endtask

  task automatic do_load(input logic cpol, input logic cpha, input logic lsb, input logic [W-1:0] tx);
    cpol_i      = cpol;
    cpha_i      = cpha;
    lsbfe_i     = lsb;
    data_mosi_i = tx;
    send_data_i = 1'b1;
    @(negedge PCLK);
    send_data_i = 1'b0;
    // Scramble inputs that must have been latched at load.
    data_mosi_i = W'($urandom);
    lsbfe_i     = 1'($urandom);
  endtask

  // Shift nbits; extra_at >= 0 inserts a load request before that bit.
  task automatic shift_bits(input logic [W-1:0] serial, input bit same, input bit noise,
                            input int nbits, input int extra_at, output logic [W-1:0] mseq);
    mseq = '0;
    for (int i = 0; i < nbits; i++) begin
      if (noise) begin
        miso_i = ~serial[i];
        strobes(1'b0, 1'b0, 1'b1);
        @(negedge PCLK);
        strobes(1'b0, 1'b0, 1'b0);
      end
      if (i == extra_at) begin
        send_data_i = 1'b1;
        data_mosi_i = '0;
        @(negedge PCLK);
        send_data_i = 1'b0;
      end
      if (same) begin
        miso_i = serial[i];
        strobes(1'b1, 1'b1, 1'b0);
        @(negedge PCLK);
        mseq[i] = mosi_o;
      end else begin
        strobes(1'b1, 1'b0, 1'b0);
        @(negedge PCLK);
        mseq[i] = mosi_o;
        miso_i = serial[i];
        strobes(1'b0, 1'b1, 1'b0);
        @(negedge PCLK);
      end
      strobes(1'b0, 1'b0, 1'b0);
    end
  endtask

  // Checks after the last receive strobe: done one cycle later, exactly once.
  task automatic finish_checks(input string tag, input logic [W-1:0] exp_rx);
    int extra;
    check({tag, " done"}, 32'(done_o), 32'd1);
    extra = 0;
    repeat (3) begin
      @(negedge PCLK);
      extra += int'(done_o);
    end
    check({tag, " single done"}, 32'(extra), 32'd0);
    check({tag, " busy after"}, 32'(busy_o), 32'd0);
    check({tag, " rx"}, 32'(data_miso_o), 32'(exp_rx));
  endtask

  task automatic full_xfer(input string tag, input logic cpol, input logic cpha, input logic lsb,
                           input logic [W-1:0] tx, input logic [W-1:0] serial,
                           input bit same, input bit noise, input int extra_at,
                           input logic [W-1:0] exp_mosi, input logic [W-1:0] exp_rx);
    logic [W-1:0] mseq;
    do_load(cpol, cpha, lsb, tx);
    check({tag, " busy after load"}, 32'(busy_o), 32'd1);
    shift_bits(serial, same, noise, W, extra_at, mseq);
    check({tag, " mosi seq"}, 32'(mseq), 32'(exp_mosi));
    finish_checks(tag, exp_rx);
  endtask

  typedef struct {
    string        name;
    logic         cpol;
    logic         cpha;
    logic         lsb;
    logic [W-1:0] tx;
    logic [W-1:0] serial;  // bit i = i-th bit presented on miso_i
    bit           same;
    bit           noise;
    logic [W-1:0] exp_mosi; // bit i = i-th bit seen on mosi_o
    logic [W-1:0] exp_rx;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [W-1:0] mseq;
    int           extra;
    logic         c0, c1, lb, sm, nz;
    logic [W-1:0] tx, ser;

    vecs[0] = '{"mode0 msb",   1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b0, 8'hA5, 8'h3C};
    vecs[1] = '{"same cycle",  1'b0, 1'b0, 1'b0, 8'h0F, 8'hFF, 1'b1, 1'b0, 8'hF0, 8'hFF};
    vecs[2] = '{"mode2 lsb",   1'b1, 1'b0, 1'b1, 8'hC3, 8'h5B, 1'b0, 1'b0, 8'hC3, 8'h5B};
    vecs[3] = '{"mode1 lsb",   1'b0, 1'b1, 1'b1, 8'h81, 8'h03, 1'b0, 1'b1, 8'h81, 8'h03};

    PRESET_n             = 1'b0;
    ss_i                 = 1'b0;
    cpol_i               = 1'b0;
    cpha_i               = 1'b0;
    lsbfe_i              = 1'b0;
    send_data_i          = 1'b0;
    data_mosi_i          = '0;
    mosi_send_sclk_i     = 1'b0;
    mosi_send_sclk0_i    = 1'b0;
    miso_recieve_sclk_i  = 1'b0;
    miso_recieve_sclk0_i = 1'b0;
    miso_i               = 1'b0;

    #1;
    check("reset mosi", 32'(mosi_o), 32'd0);
    check("reset rx",   32'(data_miso_o), 32'd0);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset done", 32'(done_o), 32'd0);
    @(negedge PCLK);
    @(negedge PCLK);
    PRESET_n = 1'b1;
    @(negedge PCLK);

    // Directed table.
    for (int v = 0; v < 4; v++) begin
      full_xfer(vecs[v].name, vecs[v].cpol, vecs[v].cpha, vecs[v].lsb, vecs[v].tx,
                vecs[v].serial, vecs[v].same, vecs[v].noise, -1,
                vecs[v].exp_mosi, vecs[v].exp_rx);
    end

    // Load request while ss_i is high is ignored.
    ss_i = 1'b1;
    do_load(1'b0, 1'b0, 1'b0, 8'hFF);
    check("load with ss high", 32'(busy_o), 32'd0);
    ss_i = 1'b0;

    // Abort after three receive strobes.
    do_load(1'b0, 1'b0, 1'b0, 8'hFF);
    shift_bits(8'h07, 1'b0, 1'b0, 3, -1, mseq);
    ss_i = 1'b1;
    @(negedge PCLK);
    check("abort busy", 32'(busy_o), 32'd0);
    check("abort mosi hold", 32'(mosi_o), 32'd1);
    extra = int'(done_o);
    repeat (3) begin
      @(negedge PCLK);
      extra += int'(done_o);
    end
    check("abort no done", 32'(extra), 32'd0);
    check("abort rx kept", 32'(data_miso_o), 32'h03);
    ss_i = 1'b0;
    @(negedge PCLK);
    full_xfer("after abort", 1'b0, 1'b0, 1'b0, 8'h55, 8'hC5, 1'b0, 1'b0, -1,
              model_mosi(8'h55, 1'b0), model_rx(8'hC5, 1'b0));

    // Extra load mid-transfer must not disturb the running word.
    full_xfer("mid load", 1'b0, 1'b0, 1'b0, 8'h5A, 8'h96, 1'b0, 1'b0, 3,
              model_mosi(8'h5A, 1'b0), model_rx(8'h96, 1'b0));
`ifdef SPI_SHIFT_OVERRUN_EN
    check("overrun set", 32'(overrun_o), 32'd1);
`endif

    // Asynchronous reset in the middle of a transfer.
    do_load(1'b0, 1'b0, 1'b0, 8'hFF);
`ifdef SPI_SHIFT_OVERRUN_EN
    check("overrun cleared by load", 32'(overrun_o), 32'd0);
`endif
    shift_bits(8'h00, 1'b0, 1'b0, 2, -1, mseq);
    check("pre-reset mosi", 32'(mosi_o), 32'd1);
    #2;
    PRESET_n = 1'b0;
    #1;
    check("mid reset mosi", 32'(mosi_o), 32'd0);
    check("mid reset rx",   32'(data_miso_o), 32'd0);
    check("mid reset busy", 32'(busy_o), 32'd0);
    check("mid reset done", 32'(done_o), 32'd0);
    @(negedge PCLK);
    PRESET_n = 1'b1;
    @(negedge PCLK);
    // Back in IDLE: strobes without a load do nothing.
    strobes(1'b1, 1'b1, 1'b0);
    miso_i = 1'b1;
    @(negedge PCLK);
    strobes(1'b0, 1'b0, 1'b0);
    check("idle after reset mosi", 32'(mosi_o), 32'd0);
    check("idle after reset busy", 32'(busy_o), 32'd0);
    @(negedge PCLK);
    check("idle after reset done", 32'(done_o), 32'd0);

    // Randomized transfers against the reference model.
    for (int n = 0; n < 24; n++) begin
      c0  = 1'($urandom);
      c1  = 1'($urandom);
      lb  = 1'($urandom);
      sm  = 1'($urandom);
      nz  = 1'($urandom);
      tx  = W'($urandom);
      ser = W'($urandom);
      full_xfer($sformatf("rand%0d", n), c0, c1, lb, tx, ser, sm, nz, -1,
                model_mosi(tx, lb), model_rx(ser, lb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
